// File: rtl/hf_iso14443a_tag_tx_pkg.sv
`default_nettype none
// ============================================================================
// hf_iso14443a_tag_tx_pkg
// Shared ISO14443-A tag-side constants, state encoding and Manchester helper.
// Revision: 1.0
// ============================================================================
package hf_iso14443a_tag_tx_pkg;

    localparam int C_BIT_PERIOD = 128;
    localparam int C_SUBC_HALF  = 8;
    localparam int C_FDT_CYCLES = 1172;
    localparam int C_FDT_W      = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_FDT = 3'd1,
        ST_SOF      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PARITY   = 3'd4,
        ST_EOF      = 3'd5
    } state_t;

    // Logic 1 modulates the first half-bit, logic 0 the second.
    function automatic logic manchester_mod(input logic bit_val,
                                            input logic second_half,
                                            input logic subc);
        return subc & (bit_val ^ second_half);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hf_iso14443a_tag_tx_if.sv
`default_nettype none
// ============================================================================
// hf_iso14443a_tag_tx_if
// Byte handshake between the SSP deserializer (master) and the tag transmitter.
// Revision: 1.0
// ============================================================================
interface hf_iso14443a_tag_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_abort;

    modport master (output tx_data, tx_valid, tx_last, tx_abort, input tx_ready);
    modport slave  (input tx_data, tx_valid, tx_last, tx_abort, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/hf_iso14443a_tag_tx_etu_timer.sv
`default_nettype none
// ============================================================================
// hf_iso14443a_tag_tx_etu_timer
// ETU phase counter with half-bit flag, fc/16 subcarrier and wrap strobe.
// Revision: 1.0
// ============================================================================
module hf_iso14443a_tag_tx_etu_timer
    import hf_iso14443a_tag_tx_pkg::*;
#(
    parameter int BIT_PERIOD = C_BIT_PERIOD,
    parameter int SUBC_HALF  = C_SUBC_HALF,
    parameter int PHASE_W    = $clog2(BIT_PERIOD)
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                run,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic               subc,
    output logic               second_half
);

    localparam int SUBC_BIT = $clog2(SUBC_HALF);

    assign wrap        = (phase == PHASE_W'(BIT_PERIOD - 1));
    assign second_half = (phase >= PHASE_W'(BIT_PERIOD / 2));
    // Even subcarrier half-periods are the high ones.
    assign subc        = ~phase[SUBC_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (!run || wrap) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hf_iso14443a_tag_tx.sv
`default_nettype none
// ============================================================================
// hf_iso14443a_tag_tx
// ISO14443-A tag transmitter: SOF, LSB-first bytes with odd parity, EOF.
// Revision: 1.0
// ============================================================================
module hf_iso14443a_tag_tx
    import hf_iso14443a_tag_tx_pkg::*;
#(
    parameter int BIT_PERIOD = C_BIT_PERIOD,
    parameter int SUBC_HALF  = C_SUBC_HALF,
    parameter int FDT_CYCLES = C_FDT_CYCLES,
    parameter int PARITY_EN  = 1
) (
    input  wire                  ck_1356meg,
    input  wire                  rst,
    hf_iso14443a_tag_tx_if.slave tx,
    output logic                 mod_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_underrun
);

    localparam int                   PHASE_W    = $clog2(BIT_PERIOD);
    localparam logic [C_FDT_W-1:0]   C_FDT_LAST = C_FDT_W'(FDT_CYCLES - 1);

    state_t               r_state;
    logic [C_FDT_W-1:0]   r_fdt_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_byte;
    logic                 r_last;
    logic [7:0]           r_shadow;
    logic                 r_shadow_last;
    logic                 r_shadow_full;
    logic                 r_ready;

    logic [PHASE_W-1:0]   w_phase;
    logic                 w_wrap;
    logic                 w_subc;
    logic                 w_second_half;
    logic                 w_run;
    logic                 w_accept;
    logic                 w_last_slot;
    logic                 w_have_next;
    logic [7:0]           w_next_byte;
    logic                 w_next_last;
    logic                 w_tx_bit;
    logic                 w_mod_next;

    assign w_run    = (r_state inside {ST_SOF, ST_DATA, ST_PARITY, ST_EOF}) && !tx.tx_abort;
    assign tx_busy  = (r_state != ST_IDLE);
    assign tx.tx_ready = r_ready;

    hf_iso14443a_tag_tx_etu_timer #(
        .BIT_PERIOD (BIT_PERIOD),
        .SUBC_HALF  (SUBC_HALF),
        .PHASE_W    (PHASE_W)
    ) u_etu_timer (
        .clk         (ck_1356meg),
        .rst         (rst),
        .run         (w_run),
        .phase       (w_phase),
        .wrap        (w_wrap),
        .subc        (w_subc),
        .second_half (w_second_half)
    );

    always_comb begin
        w_accept    = tx.tx_valid & r_ready;
        w_last_slot = (PARITY_EN != 0) ? (r_state == ST_PARITY)
                                       : (r_state == ST_DATA && r_bit_idx == 3'd7);
        // A byte accepted on the wrap cycle itself is as good as a full shadow.
        w_have_next = r_shadow_full | w_accept;
        w_next_byte = r_shadow_full ? r_shadow      : tx.tx_data;
        w_next_last = r_shadow_full ? r_shadow_last : tx.tx_last;
        w_tx_bit    = 1'b0;
        w_mod_next  = 1'b0;
        case (r_state)
            ST_SOF:    w_tx_bit = 1'b1;
            ST_DATA:   w_tx_bit = r_byte[r_bit_idx];
            ST_PARITY: w_tx_bit = ~^r_byte;
            default:   w_tx_bit = 1'b0;
        endcase
        if (r_state inside {ST_SOF, ST_DATA, ST_PARITY}) begin
            w_mod_next = manchester_mod(w_tx_bit, w_second_half, w_subc);
        end
    end

    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_fdt_cnt     <= '0;
            r_bit_idx     <= '0;
            r_byte        <= '0;
            r_last        <= 1'b0;
            r_shadow      <= '0;
            r_shadow_last <= 1'b0;
            r_shadow_full <= 1'b0;
            r_ready       <= 1'b0;
            mod_out       <= 1'b0;
            tx_done       <= 1'b0;
            tx_underrun   <= 1'b0;
        end else begin
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            mod_out     <= w_mod_next;
            if (tx.tx_abort) begin
                r_state       <= ST_IDLE;
                r_fdt_cnt     <= '0;
                r_bit_idx     <= '0;
                r_shadow_full <= 1'b0;
                r_ready       <= 1'b0;
                mod_out       <= 1'b0;
            end else begin
                r_ready <= 1'b0;
                if (w_accept && w_last_slot) begin
                    r_shadow      <= tx.tx_data;
                    r_shadow_last <= tx.tx_last;
                    r_shadow_full <= 1'b1;
                end
                case (r_state)
                    ST_IDLE: begin
                        r_ready <= !w_accept;
                        if (w_accept) begin
                            r_byte    <= tx.tx_data;
                            r_last    <= tx.tx_last;
                            r_fdt_cnt <= '0;
                            r_state   <= ST_WAIT_FDT;
                        end
                    end
                    ST_WAIT_FDT: begin
                        if (r_fdt_cnt >= C_FDT_LAST) begin
                            r_state <= ST_SOF;
                        end else begin
                            r_fdt_cnt <= r_fdt_cnt + 1'b1;
                        end
                    end
                    ST_SOF: begin
                        if (w_wrap) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (w_wrap && !w_last_slot) begin
                            if (r_bit_idx == 3'd7) begin
                                r_state <= ST_PARITY;
                            end
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                    ST_PARITY: ;
                    ST_EOF: begin
                        if (w_wrap) begin
                            r_state <= ST_IDLE;
                            tx_done <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
                // End of a byte's final slot: chain, finish, or starve.
                if (w_wrap && w_last_slot) begin
                    r_bit_idx <= '0;
                    if (r_last) begin
                        r_state <= ST_EOF;
                    end else if (w_have_next) begin
                        r_state       <= ST_DATA;
                        r_byte        <= w_next_byte;
                        r_last        <= w_next_last;
                        r_shadow_full <= 1'b0;
                    end else begin
                        r_state     <= ST_EOF;
                        tx_underrun <= 1'b1;
                    end
                end
                if (w_last_slot && !w_wrap && !r_last && !w_have_next) begin
                    r_ready <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hf_iso14443a_tag_tx.sv
`default_nettype none
// ============================================================================
// tb_hf_iso14443a_tag_tx
// Self-checking bench: frame waveform model, handshake, underrun, abort, reset.
// Revision: 1.0
// ============================================================================
module tb_hf_iso14443a_tag_tx;

    localparam int FDT = 1172;
    localparam int BP  = 128;

    logic clk = 1'b0;
    logic rst;
    logic mod_out, tx_busy, tx_done, tx_underrun;
    logic [7:0] fb [4];
    int errors = 0;
    int checks = 0;

    hf_iso14443a_tag_tx_if tx ();

    hf_iso14443a_tag_tx dut (
        .ck_1356meg  (clk),
        .rst         (rst),
        .tx          (tx),
        .mod_out     (mod_out),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected mod_out just after clock edge e, where edge 0 accepted the first byte.
    function automatic logic exp_mod(input int e, input int n);
        int j, b, p, k, s;
        logic v;
        if (e <= FDT) return 1'b0;
        j = e - FDT - 1;
        b = j / BP;
        p = j % BP;
        if (b == 0) begin
            v = 1'b1;
        end else if (b <= 9 * n) begin
            k = (b - 1) / 9;
            s = (b - 1) % 9;
            if (s < 8) v = fb[k][s];
            else       v = (($countones(fb[k]) % 2) == 0);
        end else begin
            return 1'b0;
        end
        return (v ? (p < BP / 2) : (p >= BP / 2)) && ((p % 16) < 8);
    endfunction

    task automatic wait_ready(input string name);
        int w = 0;
        while (tx.tx_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check({name, "_ready_idle"}, tx.tx_ready, 1);
    endtask

    task automatic run_frame(input string name, input int n, input bit end_last);
        int t_end, und_exp, acc, mism, done_cnt, done_at, und_cnt, und_at, rdy_bad, busy_bad;
        logic will_acc, allowed, ready_end;
        t_end   = FDT + BP * (2 + 9 * n);
        und_exp = end_last ? -1 : FDT + BP * (1 + 9 * n);
        acc = 0; mism = 0; done_cnt = 0; done_at = -1; und_cnt = 0; und_at = -1;
        rdy_bad = 0; busy_bad = 0; ready_end = 1'b0;
        wait_ready(name);
        tx.tx_data  = fb[0];
        tx.tx_last  = end_last && (n == 1);
        tx.tx_valid = 1'b1;
        for (int e = 0; e <= t_end + 1; e++) begin
            will_acc = tx.tx_valid && tx.tx_ready;
            tick();
            if (will_acc) begin
                acc++;
                if (acc < n) begin
                    tx.tx_data = fb[acc];
                    tx.tx_last = end_last && (acc == n - 1);
                end else begin
                    tx.tx_valid = 1'b0;
                end
            end
            if (mod_out !== exp_mod(e, n)) mism++;
            if (tx_done === 1'b1) begin done_cnt++; done_at = e; end
            if (tx_underrun === 1'b1) begin und_cnt++; und_at = e; end
            if (e <= t_end) begin
                if (tx_busy !== (e < t_end)) busy_bad++;
                allowed = 1'b0;
                for (int k = 0; k < n; k++) begin
                    if ((k < n - 1 || !end_last) &&
                        e >= FDT + BP * (9 * k + 9) && e < FDT + BP * (9 * k + 10))
                        allowed = 1'b1;
                end
                if (tx.tx_ready !== 1'b0 && !allowed) rdy_bad++;
            end else begin
                ready_end = tx.tx_ready;
            end
        end
        tx.tx_valid = 1'b0;
        check({name, "_wave_mismatches"}, mism, 0);
        check({name, "_accepted"}, acc, n);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_done_edge"}, done_at, t_end);
        check({name, "_underrun_count"}, und_cnt, end_last ? 0 : 1);
        check({name, "_underrun_edge"}, und_at, und_exp);
        check({name, "_ready_outside_window"}, rdy_bad, 0);
        check({name, "_busy_wrong"}, busy_bad, 0);
        check({name, "_ready_after_done"}, ready_end, 1);
    endtask

    initial begin
        int n, done_cnt;
        bit end_last;
        rst = 1'b1;
        tx.tx_data = '0; tx.tx_valid = 1'b0; tx.tx_last = 1'b0; tx.tx_abort = 1'b0;
        repeat (3) tick();
        check("rst_mod_out", mod_out, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_ready", tx.tx_ready, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("ready_after_reset", tx.tx_ready, 1);

        fb[0] = 8'h04;
        run_frame("single_04", 1, 1'b1);

        fb[0] = 8'h44; fb[1] = 8'h00;
        run_frame("atqa", 2, 1'b1);

        fb[0] = 8'hFF;
        run_frame("underrun_ff", 1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            end_last = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) fb[k] = 8'($urandom);
            run_frame($sformatf("rand%0d", r), n, end_last);
        end

        // Abort in the first half of data bit 3 (bit 3 forced high so mod_out would be 1).
        fb[0] = 8'($urandom) | 8'h08;
        wait_ready("abort");
        tx.tx_data = fb[0]; tx.tx_last = 1'b1; tx.tx_valid = 1'b1;
        for (int e = 0; e <= FDT + BP * 4 + 2; e++) begin
            tick();
            tx.tx_valid = 1'b0;
        end
        check("abort_pre_mod_out", mod_out, exp_mod(FDT + BP * 4 + 2, 1));
        tx.tx_abort = 1'b1;
        tick();
        tx.tx_abort = 1'b0;
        check("abort_mod_out", mod_out, 0);
        check("abort_busy", tx_busy, 0);
        done_cnt = 0;
        for (int e = 0; e < 300; e++) begin
            if (tx_done === 1'b1) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_ready", tx.tx_ready, 1);
        tx.tx_data = 8'hA5; tx.tx_last = 1'b1; tx.tx_valid = 1'b1; tx.tx_abort = 1'b1;
        tick();
        tx.tx_valid = 1'b0; tx.tx_abort = 1'b0;
        check("abort_beats_valid", tx_busy, 0);

        fb[0] = 8'($urandom); fb[1] = 8'($urandom);
        run_frame("after_abort", 2, 1'b1);

        // Asynchronous reset while SOF is modulating.
        fb[0] = 8'h5A;
        wait_ready("rst_sof");
        tx.tx_data = fb[0]; tx.tx_last = 1'b1; tx.tx_valid = 1'b1;
        for (int e = 0; e <= FDT + 3; e++) begin
            tick();
            tx.tx_valid = 1'b0;
        end
        check("sof_mod_out_before_rst", mod_out, exp_mod(FDT + 3, 1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_sof_mod_out", mod_out, 0);
        check("rst_sof_busy", tx_busy, 0);
        check("rst_sof_done", tx_done, 0);
        check("rst_sof_underrun", tx_underrun, 0);
        check("rst_sof_ready", tx.tx_ready, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("rst_sof_ready_after", tx.tx_ready, 1);
        check("rst_sof_idle", tx_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
